// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex seven-segment scanner with double-buffered display data,
// leading-zero blanking and 16-step brightness control.
module seg_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int POS_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [3:0]              bright,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     pos,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int PRE_MAX_INT = CLK_DIV / 16 - 1;
    localparam int PRE_W       = (PRE_MAX_INT > 0) ? $clog2(PRE_MAX_INT + 1) : 1;
    localparam int IDX_W       = $clog2(N_DIGITS);

    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRE_MAX_INT);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] POS_OFF  = (POS_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]      pre;
    logic [3:0]            phase;
    logic [IDX_W-1:0]      idx;
    logic                  pre_wrap;
    logic                  tick;
    logic                  boundary;

    logic [4*N_DIGITS-1:0] pend_data;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [4*N_DIGITS-1:0] act_data;
    logic [N_DIGITS-1:0]   act_dp;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            seg_next;
    logic [N_DIGITS-1:0]   pos_next;
    logic [7:0]            seg_q;
    logic [N_DIGITS-1:0]   pos_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign pre_wrap = (pre == PRE_MAX);
    assign tick     = pre_wrap && (phase == 4'd15);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            phase <= '0;
            idx   <= '0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                phase <= phase + 4'd1;
            end
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load in the boundary cycle still promotes the older pending value,
    // because the active copy reads the pre-edge pending buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data   <= '0;
            pend_dp     <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (boundary && pending) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_mask;
                pending   <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        pos_next  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib     = act_data[4*i +: 4];
                cur_dp      = act_dp[i];
                cur_blank   = blank_lz && (i != 0) && ((act_data >> (4*i)) == '0);
                pos_next[i] = (phase <= bright);
            end
        end
        seg_next = {cur_dp, cur_blank ? 7'h00 : hex7(cur_nib)};
    end

    // Polarity is folded into the registers so reset values come out inactive too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            pos_q <= POS_OFF;
        end else begin
            seg_q <= seg_next ^ SEG_OFF;
            pos_q <= pos_next ^ POS_OFF;
        end
    end

    assign seg = seg_q;
    assign pos = pos_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a cycle-count model.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic [3:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [7:0]  seg;
    logic [3:0]  pos;
    logic        pending;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(
        .N_DIGITS(4),
        .CLK_DIV(16),
        .SEG_ACTIVE_LOW(0),
        .POS_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .dp_mask(dp_mask),
        .load(load),
        .blank_lz(blank_lz),
        .bright(bright),
        .seg(seg),
        .pos(pos),
        .pending(pending),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elapsed cycles since reset release give digit and phase directly.
    int          m_c;
    int          m_d;
    int          m_ph;
    logic [15:0] m_active, m_pend, m_upper;
    logic [3:0]  m_dp_act, m_dp_pend;
    bit          m_pending;
    bit          m_blank;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_pos;
    logic        exp_pending, exp_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c = 0;
            m_active = '0; m_pend = '0; m_dp_act = '0; m_dp_pend = '0;
            m_pending = 1'b0;
            exp_seg = 8'h00; exp_pos = 4'h0; exp_pending = 1'b0; exp_fs = 1'b0;
        end else begin
            m_d     = (m_c / 16) % 4;
            m_ph    = m_c % 16;
            m_upper = m_active >> (4 * m_d);
            m_blank = blank_lz && (m_d != 0) && (m_upper == 16'h0);
            exp_seg = {m_dp_act[m_d], m_blank ? 7'h00 : HEX[m_upper[3:0]]};
            exp_pos = (m_ph <= int'(bright)) ? 4'(1 << m_d) : 4'h0;
            exp_fs  = ((m_c % 64) == 63);
            if (exp_fs && m_pending) begin
                m_active  = m_pend;
                m_dp_act  = m_dp_pend;
                m_pending = 1'b0;
            end
            if (load) begin
                m_pend    = data;
                m_dp_pend = dp_mask;
                m_pending = 1'b1;
            end
            exp_pending = m_pending;
            m_c++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("seg", 32'(seg), 32'(exp_seg));
            checkOutput("pos", 32'(pos), 32'(exp_pos));
            checkOutput("pending", 32'(pending), 32'(exp_pending));
            checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
        data    = d;
        dp_mask = dp;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic waitFrameStart();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = frame_start;
        end
        checkOutput("frame_start_timeout", 32'(seen), 32'd1);
    endtask

    // Called at a frame_start negedge: digit d phase 0 appears 16*d+1 cycles later.
    task automatic sampleDigits(input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 16) @(negedge clk);
            checkOutput($sformatf("digit%0d_seg", d), 32'(seg), 32'(e[d]));
            checkOutput($sformatf("digit%0d_pos", d), 32'(pos), 32'(1 << d));
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] r;
        int nz;

        repeat (3) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_seg", 32'(seg), 32'h00);
        checkOutput("reset_pos", 32'(pos), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_seg", 32'(seg), 32'h3F);
        checkOutput("release_pos", 32'(pos), 32'h1);

        applyStimulus(16'h12AF, 4'b0000);
        checkOutput("load_pending", 32'(pending), 32'd1);
        waitFrameStart();
        checkOutput("promote_pending", 32'(pending), 32'd0);
        sampleDigits(8'h71, 8'h77, 8'h5B, 8'h06);

        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (frame_start) cnt++;
        end
        checkOutput("frame_start_rate", 32'(cnt), 32'd4);

        applyStimulus(16'h1111, 4'b0000);
        checkOutput("midframe_pending", 32'(pending), 32'd1);
        waitFrameStart();
        checkOutput("midframe_cleared", 32'(pending), 32'd0);
        sampleDigits(8'h06, 8'h06, 8'h06, 8'h06);

        blank_lz = 1'b1;
        applyStimulus(16'h0050, 4'b1000);
        waitFrameStart();
        sampleDigits(8'h3F, 8'h6D, 8'h00, 8'h80);
        blank_lz = 1'b0;

        bright = 4'd3;
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pos != 4'h0) cnt++;
        end
        checkOutput("bright3_duty", 32'(cnt), 32'd16);
        bright = 4'd0;
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pos != 4'h0) cnt++;
        end
        checkOutput("bright0_duty", 32'(cnt), 32'd4);
        bright = 4'd15;

        waitFrameStart();
        applyStimulus(16'h2222, 4'b0000);
        repeat (62) @(negedge clk);
        applyStimulus(16'h3333, 4'b0000);
        checkOutput("boundary_load_fs", 32'(frame_start), 32'd1);
        checkOutput("boundary_load_pending", 32'(pending), 32'd1);
        @(negedge clk);
        checkOutput("boundary_older_shown", 32'(seg), 32'h5B);
        waitFrameStart();
        checkOutput("boundary_newer_promoted", 32'(pending), 32'd0);
        @(negedge clk);
        checkOutput("boundary_newer_shown", 32'(seg), 32'h4F);

        applyStimulus(16'h4444, 4'b0101);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_seg", 32'(seg), 32'h00);
        checkOutput("async_rst_pos", 32'(pos), 32'h0);
        checkOutput("async_rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("restart_seg", 32'(seg), 32'h3F);
        checkOutput("restart_pos", 32'(pos), 32'h1);

        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            load = ($urandom_range(0, 19) == 0);
            if (load) begin
                r       = $urandom;
                nz      = $urandom_range(0, 4);
                data    = r[15:0] & (16'hFFFF >> (4 * nz));
                dp_mask = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
